// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults, clear-FSM state encoding and address-width helper
package ram_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF = 8;
    typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;
    // Address bits needed for n entries, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: clear sequencer; clk/rst(async low)/init_req in, busy/clr_we/clr_addr out
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last;
    assign last = int'(cnt) == DEPTH - 1;
    assign clr_we = state == INIT;
    assign clr_addr = cnt;
    // init_req is only honoured from IDLE, so a pulse during a clear never restarts it.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= INIT;
            cnt <= '0;
            busy <= 1'b1;
        end else if (state == INIT) begin
            state <= last ? IDLE : INIT;
            cnt <= last ? '0 : cnt + ADDR_W'(1);
            busy <= !last;
        end else if (init_req) begin
            state <= INIT;
            cnt <= '0;
            busy <= 1'b1;
        end
endmodule

// File: rtl/ram_dp_init.sv
// ram_dp_init: 1W/1R RAM with byte enables, write-first bypass and sequenced clear
//   clk, rst (async low), write_en/addr/data/be, read_en/addr, init_req in;
//   READ_DATA (registered), read_valid, busy out
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [BE_W-1:0]   write_be,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              init_req,
    output logic [DATA_W-1:0] READ_DATA,
    output logic              read_valid,
    output logic              busy
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc, wr_ok, rd_ok, rd_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr, rd_idx;
    logic [DATA_W-1:0] mem_wdata, stored, merged, rd_word;
    logic [BE_W-1:0]   mem_be;

    ram_init_seq #(.DEPTH(DEPTH)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A same-cycle init_req wins over any access.
    assign acc = !busy && !init_req;
    assign wr_ok = write_en && acc && int'(write_addr) < DEPTH;
    assign rd_ok = read_en && acc;
    assign rd_in = int'(read_addr) < DEPTH;
    assign rd_idx = rd_in ? read_addr : '0;

    // Single write port shared by the clear sequence and user writes.
    assign mem_we = clr_we || wr_ok;
    assign mem_addr = clr_we ? clr_addr : write_addr;
    assign mem_wdata = clr_we ? '0 : write_data;
    assign mem_be = clr_we ? '1 : write_be;

    always_ff @(posedge clk)
        if (mem_we)
            for (int b = 0; b < BE_W; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

    // Write-first bypass: enabled bytes of a colliding write replace the stored ones.
    assign stored = mem[rd_idx];
    always_comb begin
        merged = stored;
        for (int b = 0; b < BE_W; b++)
            if (write_be[b]) merged[8*b +: 8] = write_data[8*b +: 8];
    end
    assign rd_word = !rd_in ? '0 : (wr_ok && write_addr == read_addr) ? merged : stored;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            READ_DATA <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_ok;
            if (rd_ok) READ_DATA <= rd_word;
        end
endmodule

// File: doc/ram_dp_init.md
RAM_DP_INIT -- requirements
Module: ram_dp_init

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, meaning the word width in bits, which must be a multiple of 8.
REQ-002 The block SHALL take parameter DEPTH, default 8, meaning the number of words (2..1024, not necessarily a power of two).
REQ-003 The block SHALL derive localparam ADDR_W = clog2(DEPTH) (min 1) and BE_W = DATA_W/8; neither is user-overridable.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 write_en  input  1  write strobe.
REQ-008 write_addr  input  ADDR_W  write address.
REQ-009 write_data  input  DATA_W  write word.
REQ-010 write_be  input  BE_W  byte enables; bit i enables write_data[8i+7:8i].
REQ-011 read_en  input  1  read strobe.
REQ-012 read_addr  input  ADDR_W  read address.
REQ-013 init_req  input  1  single-cycle pulse requesting a memory clear.
REQ-014 READ_DATA  output  DATA_W  registered read word.
REQ-015 read_valid  output  1  READ_DATA updated by a read accepted on the previous edge.
REQ-016 busy  output  1  clear sequence in progress; all accesses ignored.

Function
REQ-017 Control SHALL be a 2-state FSM: INIT (busy=1, clear counter active) and IDLE (busy=0).
REQ-018 In INIT, each edge SHALL write zero to entry cnt, then cnt+1; after entry DEPTH-1 is written, the FSM SHALL go to IDLE, so busy is high for exactly DEPTH cycles.
REQ-019 init_req=1 in IDLE SHALL enter INIT with cnt=0 on the next edge; init_req in INIT SHALL be ignored (no restart).
REQ-020 While busy=1, write_en and read_en SHALL be ignored, and read_valid SHALL be 0.
REQ-021 A write is accepted when write_en=1, busy=0, and write_addr<DEPTH; only enabled bytes change, on that edge.
REQ-022 A read is accepted when read_en=1 and busy=0; READ_DATA and read_valid=1 appear one cycle later (latency 1).
REQ-023 With no read accepted, read_valid SHALL be 0 and READ_DATA SHALL hold its last value.
REQ-024 On a same-cycle write and read of the same address, the read SHALL return write-first data: enabled bytes come from write_data, and the rest from the stored word.
REQ-025 A read with read_addr>=DEPTH SHALL return READ_DATA=0 with read_valid=1.
REQ-026 A write with write_addr>=DEPTH SHALL change nothing.
REQ-027 write_be=0 with write_en=1 SHALL leave memory unchanged; a colliding read returns the stored word.
REQ-028 init_req together with write_en/read_en in IDLE SHALL give init priority; the same-cycle access is dropped.

Reset
REQ-029 Asserting rst=0 SHALL immediately force READ_DATA=0, read_valid=0, state=INIT, cnt=0, and busy=1.
REQ-030 On deassertion, the clear SHALL run automatically, so all entries read 0 once busy falls.
REQ-031 Reset mid-clear or mid-access SHALL abort the operation and restart the clear from entry 0.
REQ-032 The memory array SHALL NOT be asynchronously reset; the clear is done only by the INIT sequence.

Structure
REQ-033 Shared package ram_pkg SHALL hold the clog2 function, the FSM state encoding (INIT, IDLE), and the default DATA_W/DEPTH constants.
REQ-034 The FSM and clear counter SHALL be one sub-module, ram_init_seq (outputs busy, clr_we, clr_addr); the array, byte-enable merge and read path stay in ram_dp_init.
REQ-035 The array SHALL be inferable as block or distributed RAM: one write port and one registered read port, with bypass logic outside the array.

Verification
REQ-036 Power-up: rst low 40 ns, then high -> busy=1 for exactly 8 cycles; then reads of addr 0..7 give 0x00 with read_valid one cycle after each read_en.
REQ-037 Write and read, DATA_W=8: write 0x81 to addr 1 and 0xAA to addr 0, then read 1 and 0 -> 0x81, then 0xAA, each one cycle after its read_en.
REQ-038 Byte enables and collision, DATA_W=32: addr 3 = 0x11223344; write 0xAABBCCDD with be=4'b0101 while reading addr 3 -> READ_DATA=0x11BB33DD the next cycle; a later read gives the same value.
REQ-039 Range, DEPTH=6: write 0x55 to addr 7 -> no entry changes; read addr 6 -> 0x00 with read_valid=1.
REQ-040 Clear: fill all entries with 0xFF, pulse init_req with read_en=1 -> no read_valid, busy=1 for DEPTH cycles, then every entry reads 0x00.
REQ-041 Reset mid-clear: assert rst at clear cycle 3 -> outputs 0 and busy=1 immediately; after release, busy stays high a full DEPTH cycles.
